motoro3_gate_monitor: RTL



---
 rtl/motoro3_gate_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/motoro3_gate_monitor.sv
// motoro3_gate_monitor: receive-side checker for the six half-bridge gate lines of a 3-phase motor
// Ports:
//   clkI, nRstI                 clock, asynchronous active-low reset
//   aHPi, bHPi, cHPi            high-side gates
//   aLNi, bLNi, cLNi            low-side gates (active-low when LOW_INV = 1)
//   faultClrI                   synchronous clear of sticky faults and stall
//   stepO, stepValidO, dirO     decoded commutation step (0..5), its validity, direction
//   stepPulseO                  one-cycle pulse on each accepted adjacent step change
//   periodO, periodValidO       cycles between the last two step pulses, update strobe
//   shootThruO, deadViolO       sticky leg faults
//   illegalO                    sticky illegal pattern / skipped step
//   stalledO                    no step change for STALL_CNT cycles
//   faultO                      registered OR of the sticky faults
module motoro3_gate_monitor #(
    parameter int LOW_INV   = 1,
    parameter int MIN_DEAD  = 10,
    parameter int PERIOD_W  = 24,
    parameter int STALL_CNT = 10000000
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic                aHPi,
    input  logic                aLNi,
    input  logic                bHPi,
    input  logic                bLNi,
    input  logic                cHPi,
    input  logic                cLNi,
    input  logic                faultClrI,
    output logic [2:0]          stepO,
    output logic                stepValidO,
    output logic                dirO,
    output logic                stepPulseO,
    output logic [PERIOD_W-1:0] periodO,
    output logic                periodValidO,
    output logic                shootThruO,
    output logic                deadViolO,
    output logic                illegalO,
    output logic                stalledO,
    output logic                faultO
);
    localparam int DW = $clog2(MIN_DEAD + 1);
    localparam int SW = $clog2(STALL_CNT + 1);
    localparam logic [DW-1:0] DEAD_MAX = DW'(MIN_DEAD);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CNT - 1);
    localparam logic [PERIOD_W-1:0] PER_MAX = '1;
    localparam logic [2:0] INV = (LOW_INV != 0) ? 3'b111 : 3'b000;
    // Sync flops reset to the idle level so the first decoded pattern is all legs off
    logic [5:0] syncA, syncB;
    always_ff @(posedge clkI or negedge nRstI)
        if (!nRstI) begin
            syncA <= {INV, 3'b000};
            syncB <= {INV, 3'b000};
        end else begin
            syncA <= {cLNi, bLNi, aLNi, cHPi, bHPi, aHPi};
            syncB <= syncA;
        end
    logic [2:0] hi, lo;
    assign hi = syncB[2:0];
    assign lo = syncB[5:3] ^ INV;
    logic       isValid, isHold, anyX, badPat;
    logic [2:0] vStep;
    always_comb begin
        isValid = 1'b1;
        vStep   = 3'd0;
        case ({hi, lo})
            6'b001_010: vStep = 3'd0;
            6'b001_100: vStep = 3'd1;
            6'b010_100: vStep = 3'd2;
            6'b010_001: vStep = 3'd3;
            6'b100_001: vStep = 3'd4;
            6'b100_010: vStep = 3'd5;
            default:    isValid = 1'b0;
        endcase
    end
    assign anyX   = |(hi & lo);
    assign isHold = (hi == 3'b000) && $onehot0(lo);
    assign badPat = !anyX && !isValid && !isHold;
    logic          armed, lock, havePrev;
    logic [SW-1:0] stallCnt;
    logic [PERIOD_W-1:0] perCnt;
    logic [2:0]    stepUp, stepDn;
    logic          change, first, fwd, rev, skip, pulse, stallHit;
    assign stepUp = (stepO == 3'd5) ? 3'd0 : stepO + 3'd1;
    assign stepDn = (stepO == 3'd0) ? 3'd5 : stepO - 3'd1;
    // After a stall the held sector must not re-validate itself; lock demands real motion
    assign change   = isValid && ((vStep != stepO) || (armed && !lock));
    assign first    = change && armed;
    assign fwd      = change && !armed && (vStep == stepUp);
    assign rev      = change && !armed && (vStep == stepDn);
    assign skip     = change && !armed && !fwd && !rev;
    assign pulse    = fwd || rev;
    // Stall timing only runs once a step has been established
    assign stallHit = !armed && !change && (stallCnt == STALL_LAST);
    logic [2:0] hiPrev, loPrev, deadHit;
    for (genvar i = 0; i < 3; i++) begin : g_leg
        logic [DW-1:0] gap;
        logic          lastLo, lastAct, onH, onL, wasH, wasL, tooSoon;
        assign onH     = hi[i] & ~lo[i];
        assign onL     = lo[i] & ~hi[i];
        assign wasH    = hiPrev[i] & ~loPrev[i];
        assign wasL    = loPrev[i] & ~hiPrev[i];
        assign tooSoon = lastAct && (gap < DEAD_MAX);
        // gap is zero on a direct H<->L swap, so that case needs no separate term
        assign deadHit[i] = tooSoon && ((onH && !wasH && lastLo) || (onL && !wasL && !lastLo));
        always_ff @(posedge clkI or negedge nRstI)
            if (!nRstI) begin
                gap     <= '0;
                lastLo  <= 1'b0;
                lastAct <= 1'b0;
            end else begin
                gap <= (hi[i] | lo[i]) ? '0 : (gap == DEAD_MAX) ? gap : gap + 1'b1;
                if (onH || onL) begin
                    lastAct <= 1'b1;
                    lastLo  <= onL;
                end
            end
    end
    always_ff @(posedge clkI or negedge nRstI)
        if (!nRstI) begin
            hiPrev       <= '0;
            loPrev       <= '0;
            stepO        <= '0;
            stepValidO   <= 1'b0;
            dirO         <= 1'b0;
            stepPulseO   <= 1'b0;
            periodO      <= '0;
            periodValidO <= 1'b0;
            perCnt       <= '0;
            havePrev     <= 1'b0;
            stallCnt     <= '0;
            armed        <= 1'b1;
            lock         <= 1'b0;
            stalledO     <= 1'b0;
            shootThruO   <= 1'b0;
            deadViolO    <= 1'b0;
            illegalO     <= 1'b0;
            faultO       <= 1'b0;
        end else begin
            hiPrev       <= hi;
            loPrev       <= lo;
            stepO        <= change ? vStep : stepO;
            stepValidO   <= stallHit ? 1'b0 : first ? 1'b1 : stepValidO;
            dirO         <= fwd ? 1'b0 : rev ? 1'b1 : dirO;
            stepPulseO   <= pulse;
            periodValidO <= pulse && havePrev;
            periodO      <= (pulse && havePrev) ? perCnt : periodO;
            perCnt       <= pulse ? PERIOD_W'(1) : (perCnt == PER_MAX) ? perCnt : perCnt + 1'b1;
            havePrev     <= pulse || (havePrev && !first && !skip && !stallHit);
            stallCnt     <= change ? '0 : armed ? stallCnt : stallCnt + 1'b1;
            armed        <= stallHit || (armed && !first);
            lock         <= stallHit || (lock && !first);
            stalledO     <= stallHit || (stalledO && !first && !faultClrI);
            shootThruO   <= anyX || (shootThruO && !faultClrI);
            deadViolO    <= (|deadHit) || (deadViolO && !faultClrI);
            illegalO     <= badPat || skip || (illegalO && !faultClrI);
            faultO       <= shootThruO | deadViolO | illegalO;
        end
endmodule
